// File: rtl/jump_pred_ctrl.sv
// jump_pred_ctrl: sequences a global-history jump predictor between fetch and execute.
// Fetch pushes branches into an in-flight FIFO; the predictor answer fills the entry a
// cycle later. Execute resolves the FIFO head in order, updating the predictor and
// detecting mispredicts, which redirect fetch, flush history and hold fetch off briefly.
module jump_pred_ctrl #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  enable,
  input  logic                  i_stall,
  input  logic                  i_br_valid,
  input  logic [ADDR_WIDTH-1:0] i_br_addr,
  output logic                  o_br_ready,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_shift_hist,
  input  logic                  i_pred_jump,
  input  logic                  i_pred_valid,
  output logic                  o_pred_strobe,
  output logic                  o_pred_taken,
  input  logic                  i_res_valid,
  input  logic [ADDR_WIDTH-1:0] i_res_addr,
  input  logic                  i_res_taken,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_wr_jump,
  output logic                  o_flush_hist,
  output logic                  o_redirect,
  output logic                  o_err,
  output logic [CNT_WIDTH-1:0]  o_hit_cnt,
  output logic [CNT_WIDTH-1:0]  o_miss_cnt
);

  localparam int PW    = $clog2(DEPTH);
  localparam int OCC_W = PW + 1;
  localparam int FW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [DEPTH-1:0]      taken_q, taken_d;
  logic [DEPTH-1:0]      pend_q, pend_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [PW-1:0]         fill_idx_q, fill_idx_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  fill_q, fill_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  hit_q, hit_d;
  logic [CNT_WIDTH-1:0]  miss_q, miss_d;

  logic                  adv, act, empty, full, live_pred, head_pred;
  logic                  res_ok, res_empty, mispred, ready, push;
  logic [ADDR_WIDTH-1:0] head_addr;

  // Decode this cycle's handshakes: push acceptance, resolve validity and mispredict.
  always_comb begin
    adv       = enable & ~i_stall;
    act       = adv & nreset;
    empty     = (occ_q == '0);
    full      = (occ_q == OCC_W'(DEPTH));
    live_pred = i_pred_valid & i_pred_jump;
    head_addr = addr_q[head_q];
    head_pred = pend_q[head_q] ? live_pred : taken_q[head_q];
    res_ok    = act & i_res_valid & ~empty;
    res_empty = act & i_res_valid & empty;
    mispred   = res_ok & (head_pred != i_res_taken);
    ready     = act & (state_q == ST_RUN) & ~full & ~mispred;
    push      = ready & i_br_valid;
  end

  // Next-state for the FIFO, flush timer, sticky error and statistic counters.
  always_comb begin
    addr_d     = addr_q;
    taken_d    = taken_q;
    pend_d     = pend_q;
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    fill_d     = 1'b0;
    fill_idx_d = fill_idx_q;
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    err_d      = err_q;
    hit_d      = hit_q;
    miss_d     = miss_q;

    if (fill_q) begin
      taken_d[fill_idx_q] = live_pred;
      pend_d[fill_idx_q]  = 1'b0;
    end

    if (push) begin
      addr_d[tail_q]  = i_br_addr;
      taken_d[tail_q] = 1'b0;
      pend_d[tail_q]  = 1'b1;
      tail_d          = tail_q + PW'(1);
      fill_d          = 1'b1;
      fill_idx_d      = tail_q;
    end

    if (res_ok) begin
      head_d = head_q + PW'(1);
      if (mispred) begin
        if (~&miss_q) miss_d = miss_q + CNT_WIDTH'(1);
      end else begin
        if (~&hit_q) hit_d = hit_q + CNT_WIDTH'(1);
      end
    end

    occ_d = occ_q + OCC_W'(push) - OCC_W'(res_ok);

    if (res_empty | (res_ok & (i_res_addr != head_addr))) err_d = 1'b1;

    if (state_q == ST_FLUSH) begin
      if (fcnt_q == '0) state_d = ST_RUN;
      else              fcnt_d  = fcnt_q - FW'(1);
    end

    if (mispred) begin
      head_d  = '0;
      tail_d  = '0;
      occ_d   = '0;
      pend_d  = '0;
      fill_d  = 1'b0;
      state_d = ST_FLUSH;
      fcnt_d  = FW'(FLUSH_CYCLES - 1);
    end
  end

  // State registers: synchronous reset, otherwise frozen unless the pipeline advances.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= ST_RUN;
      fcnt_q     <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
      taken_q    <= '0;
      pend_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_idx_q <= '0;
      occ_q      <= '0;
      fill_q     <= 1'b0;
      err_q      <= 1'b0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else if (adv) begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      addr_q     <= addr_d;
      taken_q    <= taken_d;
      pend_q     <= pend_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_idx_q <= fill_idx_d;
      occ_q      <= occ_d;
      fill_q     <= fill_d;
      err_q      <= err_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  assign o_br_ready    = ready;
  assign o_rd_addr     = i_br_addr;
  assign o_shift_hist  = push;
  assign o_pred_strobe = act & fill_q;
  assign o_pred_taken  = act & fill_q & live_pred;
  assign o_wr_en       = res_ok;
  assign o_wr_addr     = res_ok ? head_addr : '0;
  assign o_wr_jump     = res_ok & i_res_taken;
  assign o_flush_hist  = mispred;
  assign o_redirect    = mispred;
  assign o_err         = err_q;
  assign o_hit_cnt     = hit_q;
  assign o_miss_cnt    = miss_q;

endmodule

// File: tb/tb_jump_pred_ctrl.sv
// tb_jump_pred_ctrl: cycle-vector table plus hand-written reset/error sequences.
// Write addresses are predicted by a scoreboard of accepted branch PCs.
module tb_jump_pred_ctrl;

  localparam int AW = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          nreset, enable, i_stall;
  logic          i_br_valid, i_pred_jump, i_pred_valid, i_res_valid, i_res_taken;
  logic [AW-1:0] i_br_addr, i_res_addr;
  logic          o_br_ready, o_shift_hist, o_pred_strobe, o_pred_taken;
  logic          o_wr_en, o_wr_jump, o_flush_hist, o_redirect, o_err;
  logic [AW-1:0] o_rd_addr, o_wr_addr;
  logic [CW-1:0] o_hit_cnt, o_miss_cnt;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] sb_q[$];

  typedef struct {
    logic          brv;
    logic [AW-1:0] bra;
    logic          pv, pj, rv;
    logic [AW-1:0] ra;
    logic          rt, stall;
    logic          e_rdy, e_wr, e_red, e_stb, e_pt;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  jump_pred_ctrl #(.ADDR_WIDTH(AW), .DEPTH(4), .FLUSH_CYCLES(2), .CNT_WIDTH(CW)) dut (
    .clk(clk), .nreset(nreset), .enable(enable), .i_stall(i_stall),
    .i_br_valid(i_br_valid), .i_br_addr(i_br_addr), .o_br_ready(o_br_ready),
    .o_rd_addr(o_rd_addr), .o_shift_hist(o_shift_hist),
    .i_pred_jump(i_pred_jump), .i_pred_valid(i_pred_valid),
    .o_pred_strobe(o_pred_strobe), .o_pred_taken(o_pred_taken),
    .i_res_valid(i_res_valid), .i_res_addr(i_res_addr), .i_res_taken(i_res_taken),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_jump(o_wr_jump),
    .o_flush_hist(o_flush_hist), .o_redirect(o_redirect), .o_err(o_err),
    .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt)
  );

  function automatic vec_t mk(logic brv, logic [AW-1:0] bra, logic pv, logic pj,
                              logic rv, logic [AW-1:0] ra, logic rt, logic stall,
                              logic e_rdy, logic e_wr, logic e_red, logic e_stb, logic e_pt);
    vec_t v;
    v.brv = brv; v.bra = bra; v.pv = pv; v.pj = pj; v.rv = rv; v.ra = ra; v.rt = rt;
    v.stall = stall; v.e_rdy = e_rdy; v.e_wr = e_wr; v.e_red = e_red;
    v.e_stb = e_stb; v.e_pt = e_pt;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Called at posedge+1: drives one cycle, checks at the falling edge, returns at next posedge+1.
  task automatic apply_stimulus(input vec_t v);
    logic [AW-1:0] exp_addr;
    i_br_valid = v.brv; i_br_addr = v.bra; i_pred_valid = v.pv; i_pred_jump = v.pj;
    i_res_valid = v.rv; i_res_addr = v.ra; i_res_taken = v.rt; i_stall = v.stall;
    #4;
    if (!v.stall) check_output("br_ready", o_br_ready, v.e_rdy);
    check_output("shift_hist", o_shift_hist, v.brv & v.e_rdy & ~v.stall);
    check_output("wr_en", o_wr_en, v.e_wr);
    check_output("redirect", o_redirect, v.e_red);
    check_output("flush_hist", o_flush_hist, v.e_red);
    check_output("pred_strobe", o_pred_strobe, v.e_stb);
    check_output("pred_taken", o_pred_taken, v.e_pt);
    if (v.e_wr) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_underflow: got wr_addr 0x%0h, expected no write", o_wr_addr);
      end else begin
        exp_addr = sb_q.pop_front();
        check_output("wr_addr", o_wr_addr, exp_addr);
        check_output("wr_jump", o_wr_jump, v.rt);
      end
    end
    if (v.e_red) sb_q.delete();
    if (v.brv && v.e_rdy && !v.stall) sb_q.push_back(v.bra);
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges with live-looking inputs and checks all outputs are quiet.
  task automatic do_reset();
    nreset = 1'b0; enable = 1'b1; i_stall = 1'b0;
    i_br_valid = 1'b1; i_br_addr = 'h55; i_pred_valid = 1'b1; i_pred_jump = 1'b1;
    i_res_valid = 1'b1; i_res_addr = 'h55; i_res_taken = 1'b0;
    repeat (2) @(posedge clk);
    #5;
    check_output("rst_ready", o_br_ready, 0);
    check_output("rst_shift", o_shift_hist, 0);
    check_output("rst_strobe", o_pred_strobe, 0);
    check_output("rst_ptaken", o_pred_taken, 0);
    check_output("rst_wr_en", o_wr_en, 0);
    check_output("rst_wr_addr", o_wr_addr, 0);
    check_output("rst_wr_jump", o_wr_jump, 0);
    check_output("rst_redirect", o_redirect, 0);
    check_output("rst_flush", o_flush_hist, 0);
    check_output("rst_err", o_err, 0);
    check_output("rst_hit", o_hit_cnt, 0);
    check_output("rst_miss", o_miss_cnt, 0);
    sb_q.delete();
    @(posedge clk);
    #1;
    nreset = 1'b1;
    i_br_valid = 1'b0; i_res_valid = 1'b0; i_pred_valid = 1'b0; i_pred_jump = 1'b0;
  endtask

  initial begin
    // brv bra pv pj rv ra rt stall | rdy wr red stb pt
    // Hit, then mispredict with a second in-flight entry and a flush window.
    tbl.push_back(mk(1,'h100,0,0,0,0,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,1,1,0,0,0,0,     1,0,0,1,1));
    tbl.push_back(mk(0,0,0,0,1,'h100,1,0, 1,1,0,0,0));
    tbl.push_back(mk(1,'h200,0,0,0,0,0,0, 1,0,0,0,0));
    tbl.push_back(mk(1,'h208,1,0,0,0,0,0, 1,0,0,1,0));
    tbl.push_back(mk(0,0,1,1,1,'h200,1,0, 0,1,1,1,1));
    tbl.push_back(mk(1,'h210,0,0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,'h210,0,0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,'h220,0,0,0,0,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,1,1,1,'h220,1,0, 1,1,0,1,1));
    // Fill to full, full push rejection, pop-then-push, occupancy-neutral push+pop.
    tbl.push_back(mk(1,'h300,0,0,0,0,0,0, 1,0,0,0,0));
    tbl.push_back(mk(1,'h310,1,1,0,0,0,0, 1,0,0,1,1));
    tbl.push_back(mk(1,'h320,1,1,0,0,0,0, 1,0,0,1,1));
    tbl.push_back(mk(1,'h330,1,1,0,0,0,0, 1,0,0,1,1));
    tbl.push_back(mk(1,'h340,1,1,0,0,0,0, 0,0,0,1,1));
    tbl.push_back(mk(1,'h340,0,0,1,'h300,1,0, 0,1,0,0,0));
    tbl.push_back(mk(1,'h340,0,0,0,0,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,'h310,1,0, 0,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,'h320,1,0, 1,1,0,0,0));
    tbl.push_back(mk(1,'h350,0,0,1,'h330,1,0, 1,1,0,0,0));
    tbl.push_back(mk(1,'h360,1,1,0,0,0,0, 1,0,0,1,1));
    tbl.push_back(mk(1,'h370,1,1,0,0,0,0, 1,0,0,1,1));
    tbl.push_back(mk(1,'h380,1,1,0,0,0,0, 0,0,0,1,1));
    tbl.push_back(mk(0,0,0,0,1,'h340,0,0, 0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,'h350,1,0, 1,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,'h360,1,0, 1,1,0,0,0));
    // Stall freezes push+resolve and a pending fill; both resume afterwards.
    tbl.push_back(mk(1,'h390,0,0,1,'h370,1,1, 0,0,0,0,0));
    tbl.push_back(mk(1,'h390,0,0,1,'h370,1,0, 1,1,0,0,0));
    tbl.push_back(mk(0,0,1,1,0,0,0,1,     0,0,0,0,0));
    tbl.push_back(mk(0,0,1,1,0,0,0,0,     1,0,0,1,1));
    tbl.push_back(mk(0,0,0,0,1,'h390,1,0, 1,1,0,0,0));

    do_reset();
    foreach (tbl[i]) apply_stimulus(tbl[i]);
    check_output("tbl_hit", o_hit_cnt, 11);
    check_output("tbl_miss", o_miss_cnt, 1);
    check_output("tbl_err", o_err, 0);

    // Resolve against an empty FIFO: no write, sticky error, counters untouched.
    apply_stimulus(mk(0,0,0,0,1,'h999,1,0, 1,0,0,0,0));
    check_output("empty_err", o_err, 1);
    check_output("empty_hit", o_hit_cnt, 11);
    apply_stimulus(mk(0,0,0,0,0,0,0,0,     1,0,0,0,0));
    check_output("err_sticky", o_err, 1);

    // Address mismatch: write still targets the stored head PC.
    do_reset();
    apply_stimulus(mk(1,'h400,0,0,0,0,0,0, 1,0,0,0,0));
    apply_stimulus(mk(0,0,1,1,0,0,0,0,     1,0,0,1,1));
    apply_stimulus(mk(0,0,0,0,1,'h404,1,0, 1,1,0,0,0));
    check_output("addr_err", o_err, 1);
    check_output("addr_hit", o_hit_cnt, 1);

    // Resolve while the only entry is pushed in the same cycle counts as empty.
    do_reset();
    apply_stimulus(mk(1,'h410,0,0,1,'h410,1,0, 1,0,0,0,0));
    check_output("same_cyc_err", o_err, 1);
    apply_stimulus(mk(0,0,1,1,0,0,0,0,     1,0,0,1,1));
    apply_stimulus(mk(0,0,0,0,1,'h410,1,0, 1,1,0,0,0));

    // Reset in the middle of the flush window leaves fetch ready straight away.
    do_reset();
    apply_stimulus(mk(1,'h500,0,0,0,0,0,0, 1,0,0,0,0));
    apply_stimulus(mk(0,0,1,0,0,0,0,0,     1,0,0,1,0));
    apply_stimulus(mk(0,0,0,0,1,'h500,1,0, 0,1,1,0,0));
    check_output("flush_miss", o_miss_cnt, 1);
    do_reset();
    apply_stimulus(mk(1,'h510,0,0,0,0,0,0, 1,0,0,0,0));

    // Reset with a full FIFO empties it: the next resolve sees the new branch at the head.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] a;
      a = 'h600 + 'h10 * k;
      apply_stimulus(mk(1,a,1,1,0,0,0,0, 1,0,0,(k != 0),(k != 0)));
    end
    apply_stimulus(mk(1,'h640,1,1,0,0,0,0, 0,0,0,1,1));
    do_reset();
    apply_stimulus(mk(1,'h700,0,0,0,0,0,0, 1,0,0,0,0));
    apply_stimulus(mk(0,0,1,1,0,0,0,0,     1,0,0,1,1));
    apply_stimulus(mk(0,0,0,0,1,'h700,1,0, 1,1,0,0,0));
    check_output("full_rst_hit", o_hit_cnt, 1);
    check_output("full_rst_err", o_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
